// File: rtl/prefetch_unit_pkg.sv
// Shared constants and FSM state encoding for the instruction prefetch unit.
package prefetch_unit_pkg;

    localparam logic [31:0]  NOP                 = 32'h0000_0013;
    localparam int unsigned  EX_INSTR_MISALIGNED = 0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DROP = 2'd1,
        ST_HALT = 2'd2
    } pf_state_e;

    function automatic logic addr_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/prefetch_unit_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and a clear that beats push/pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: credit-limited single-outstanding fetch into a small FIFO,
// with flush redirect, stale-response drop and misaligned-target halt.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       EX_W     = 4,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    output logic               mem_rd_enable,
    input  logic [INSTR_W-1:0] mem_rd_data,
    input  logic               mem_rd_ready,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    input  logic               stall,
    output logic               pipeline_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  PC,
    output logic [EX_W-1:0]    exception,
    output logic               exception_valid
);

    localparam int unsigned ENT_W = ADDR_W + INSTR_W + EX_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    pf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic              outstanding_q, outstanding_d;
    logic              ex_pending_q, ex_pending_d;
    logic              started_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_wdata, fifo_rdata;

    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [EX_W-1:0]    head_ex;
    logic               head_exv;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pipeline_valid = !fifo_empty;
    assign fifo_pop       = pipeline_valid && !stall;
    assign {head_pc, head_instr, head_ex, head_exv} = fifo_rdata;

    always_comb begin
        if (fifo_empty) begin
            PC              = '0;
            instr           = INSTR_W'(NOP);
            exception       = '0;
            exception_valid = 1'b0;
        end else begin
            PC              = head_pc;
            instr           = head_instr;
            exception       = head_ex;
            exception_valid = head_exv;
        end
    end

    // An issued request keeps its address even after a flush retargets fetch_pc.
    assign mem_rd_addr   = outstanding_q ? req_addr_q : fetch_pc_q;
    assign outstanding_d = mem_rd_enable && !mem_rd_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        ex_pending_d  = ex_pending_q;
        mem_rd_enable = 1'b0;
        fifo_push     = 1'b0;
        fifo_wdata    = {fetch_pc_q, mem_rd_data, EX_W'(0), 1'b0};

        case (state_q)
            ST_RUN:  mem_rd_enable = started_q &&
                                     (outstanding_q || (fifo_count < CNT_W'(DEPTH)));
            ST_DROP: mem_rd_enable = 1'b1;
            default: mem_rd_enable = 1'b0;
        endcase

        if (flush) begin
            fetch_pc_d   = flush_addr;
            ex_pending_d = addr_misaligned(flush_addr[1:0]);
            if (outstanding_d)
                state_d = ST_DROP;
            else if (addr_misaligned(flush_addr[1:0]))
                state_d = ST_HALT;
            else
                state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_rd_enable && mem_rd_ready) begin
                        fifo_push  = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    end
                end
                ST_DROP: begin
                    // fetch_pc still holds the flush target, so it decides where we land.
                    if (mem_rd_ready)
                        state_d = addr_misaligned(fetch_pc_q[1:0]) ? ST_HALT : ST_RUN;
                end
                default: state_d = state_q;
            endcase

            if (ex_pending_q && !fifo_full) begin
                fifo_push    = 1'b1;
                fifo_wdata   = {fetch_pc_q, INSTR_W'(NOP), EX_W'(EX_INSTR_MISALIGNED), 1'b1};
                ex_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= '0;
            outstanding_q <= 1'b0;
            ex_pending_q  <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= mem_rd_addr;
            outstanding_q <= outstanding_d;
            ex_pending_q  <= ex_pending_d;
            started_q     <= 1'b1;
        end
    end

endmodule
